// File: rtl/nf_reset_seq_pkg.sv
// Shared types, constants and elaboration-time parameter check for the
// nf_reset_sequencer block.
package nf_reset_seq_pkg;

  typedef enum logic [1:0] {
    ST_HOLD = 2'd0,
    ST_WAIT = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } seq_state_e;

  localparam int SEQ_STAGE_W = 4;

  // Counter compares use equality only, so every limit must be reachable
  // without the counter wrapping.
  function automatic bit params_ok(input int num_ch, input int cnt_width,
                                   input int hold_cycles, input int stage_gap,
                                   input int timeout_cycles);
    longint lim;
    if (cnt_width < 1 || cnt_width > 62) return 1'b0;
    lim = longint'(1) << cnt_width;
    return (num_ch >= 1) && (num_ch <= 16) &&
           (hold_cycles >= 2) && (longint'(hold_cycles) < lim) &&
           (stage_gap >= 1) && (longint'(stage_gap) <= lim) &&
           (timeout_cycles >= 1) && (longint'(timeout_cycles) <= lim);
  endfunction

endpackage

// File: rtl/nf_sync_2ff.sv
// Two-flop synchroniser for level inputs; flops clear to 0 on the
// synchronous active-low reset.
module nf_sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_d, meta_q;
  logic [WIDTH-1:0] sync_d, sync_q;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/nf_reset_sequencer.sv
// Staged multi-channel reset release sequencer (HOLD -> WAIT/GAP per channel -> DONE).
// Define NF_RESET_SEQ_READY_SYNC_EN to pass ch_ready through a two-flop synchroniser.
module nf_reset_sequencer
  import nf_reset_seq_pkg::*;
#(
  parameter int NUM_CH         = 4,
  parameter int CNT_WIDTH      = 16,
  parameter int HOLD_CYCLES    = 200,
  parameter int STAGE_GAP      = 16,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic                   axis_aclk,
  input  logic                   axis_resetn,
  input  logic [NUM_CH-1:0]      ch_ready,
  input  logic                   sw_rst_req,
  output logic [NUM_CH-1:0]      rst_n_o,
  output logic                   seq_done,
  output logic                   seq_busy,
  output logic [SEQ_STAGE_W-1:0] seq_stage,
  output logic [NUM_CH-1:0]      timeout_err
);

  if (!params_ok(NUM_CH, CNT_WIDTH, HOLD_CYCLES, STAGE_GAP, TIMEOUT_CYCLES)) begin : g_param_err
    $error("nf_reset_sequencer: illegal parameter combination");
  end

  localparam logic [CNT_WIDTH-1:0]   HOLD_LAST = CNT_WIDTH'(HOLD_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0]   GAP_LAST  = CNT_WIDTH'(STAGE_GAP - 1);
  localparam logic [CNT_WIDTH-1:0]   TO_LAST   = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [SEQ_STAGE_W-1:0] LAST_IDX  = SEQ_STAGE_W'(NUM_CH - 1);

  seq_state_e             state_d, state_q;
  logic [CNT_WIDTH-1:0]   cnt_d, cnt_q;
  logic [SEQ_STAGE_W-1:0] idx_d, idx_q;
  logic [NUM_CH-1:0]      rst_n_d, rst_n_q;
  logic [NUM_CH-1:0]      terr_d, terr_q;
  logic [NUM_CH-1:0]      ready_eff;
  logic [NUM_CH-1:0]      idx_mask;
  logic                   ready_cur;

`ifdef NF_RESET_SEQ_READY_SYNC_EN
  nf_sync_2ff #(.WIDTH(NUM_CH)) u_ready_sync (
    .clk   (axis_aclk),
    .rst_n (axis_resetn),
    .d     (ch_ready),
    .q     (ready_eff)
  );
`else
  assign ready_eff = ch_ready;
`endif

  // One-hot of the channel under sequencing; avoids a width-mismatched variable index.
  always_comb begin
    idx_mask  = '0;
    ready_cur = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (idx_q == SEQ_STAGE_W'(k)) begin
        idx_mask[k] = 1'b1;
        ready_cur   = ready_eff[k];
      end
    end
  end

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    rst_n_d = rst_n_q;
    terr_d  = terr_q;

    unique case (state_q)
      ST_HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          state_d = ST_WAIT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end
      ST_WAIT: begin
        if (ready_cur || (cnt_q == TO_LAST)) begin
          rst_n_d = rst_n_q | idx_mask;
          if (!ready_cur) terr_d = terr_q | idx_mask;
          cnt_d   = '0;
          state_d = (idx_q == LAST_IDX) ? ST_DONE : ST_GAP;
        end else begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end
      ST_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          idx_d   = idx_q + SEQ_STAGE_W'(1);
          state_d = ST_WAIT;
        end else begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end
      ST_DONE: ;
      default: state_d = ST_HOLD;
    endcase

    // Software request restarts the whole sequence from any state.
    if (sw_rst_req) begin
      state_d = ST_HOLD;
      cnt_d   = '0;
      idx_d   = '0;
      rst_n_d = '0;
      terr_d  = '0;
    end
  end

  always_ff @(posedge axis_aclk) begin
    if (!axis_resetn) begin
      state_q <= ST_HOLD;
      cnt_q   <= '0;
      idx_q   <= '0;
      rst_n_q <= '0;
      terr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      rst_n_q <= rst_n_d;
      terr_q  <= terr_d;
    end
  end

  assign rst_n_o     = rst_n_q;
  assign timeout_err = terr_q;
  assign seq_done    = (state_q == ST_DONE);
  assign seq_busy    = (state_q != ST_DONE);
  assign seq_stage   = idx_q;

endmodule

// File: tb/tb_nf_reset_sequencer.sv
// Scoreboard bench for nf_reset_sequencer: expected output transitions are queued
// with their edge numbers and matched against every observed output change.
module tb_nf_reset_sequencer;

  localparam int NUM_CH = 4;
  localparam int H      = 200;
  localparam int G      = 16;
  localparam int T      = 1000;
`ifdef NF_RESET_SEQ_READY_SYNC_EN
  localparam int SYNC_LAG = 2;
`else
  localparam int SYNC_LAG = 0;
`endif

  logic              clk = 1'b0;
  logic              axis_resetn = 1'b0;
  logic [NUM_CH-1:0] ch_ready = '0;
  logic              sw_rst_req = 1'b0;
  logic [NUM_CH-1:0] rst_n_o;
  logic              seq_done;
  logic              seq_busy;
  logic [3:0]        seq_stage;
  logic [NUM_CH-1:0] timeout_err;

  nf_reset_sequencer #(
    .NUM_CH(NUM_CH), .CNT_WIDTH(16), .HOLD_CYCLES(H),
    .STAGE_GAP(G), .TIMEOUT_CYCLES(T)
  ) dut (
    .axis_aclk   (clk),
    .axis_resetn (axis_resetn),
    .ch_ready    (ch_ready),
    .sw_rst_req  (sw_rst_req),
    .rst_n_o     (rst_n_o),
    .seq_done    (seq_done),
    .seq_busy    (seq_busy),
    .seq_stage   (seq_stage),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         edge_n;
    logic [3:0] rst;
    logic [3:0] terr;
    logic       done;
  } ev_t;

  ev_t  exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   ecnt    = 0;
  bit   mon_en  = 1'b0;
  logic [8:0] prev_s;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, ecnt);
    end
  endtask

  function automatic int hi_bit(input logic [3:0] v);
    int r = 0;
    for (int k = 0; k < 4; k++) if (v[k]) r = k;
    return r;
  endfunction

  task automatic push_ev(input int e, input logic [3:0] r, input logic [3:0] t, input logic d);
    ev_t ev;
    ev.edge_n = e; ev.rst = r; ev.terr = t; ev.done = d;
    exp_q.push_back(ev);
  endtask

  // Edge number since the last reset edge: E1 is the first edge with resetn high.
  always @(posedge clk) begin
    if (!axis_resetn) ecnt <= 0;
    else              ecnt <= ecnt + 1;
  end

  always @(negedge clk) begin
    logic [8:0] cur;
    ev_t ev;
    cur = {seq_done, timeout_err, rst_n_o};
    if (mon_en && cur !== prev_s) begin
      if (exp_q.size() == 0) begin
        check("unexpected_change", {23'd0, cur}, {23'd0, prev_s});
      end else begin
        ev = exp_q.pop_front();
        check("edge", ecnt, ev.edge_n);
        check("rst_n_o", rst_n_o, ev.rst);
        check("timeout_err", timeout_err, ev.terr);
        check("seq_done", seq_done, ev.done);
        check("seq_busy", seq_busy, !ev.done);
        check("seq_stage", seq_stage, hi_bit(ev.rst));
      end
      prev_s = cur;
    end
  end

  task automatic wait_edge(input int n);
    int guard = 0;
    while (ecnt < n && guard < 5000) begin
      @(posedge clk); #1;
      guard++;
    end
    check("wait_edge", ecnt, n);
  endtask

  task automatic do_reset(input logic [3:0] rdy);
    mon_en = 1'b0;
    exp_q.delete();
    ch_ready = rdy;
    sw_rst_req = 1'b0;
    axis_resetn = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("reset_rst_n_o", rst_n_o, 4'h0);
    check("reset_done", seq_done, 1'b0);
    check("reset_busy", seq_busy, 1'b1);
    check("reset_stage", seq_stage, 4'd0);
    check("reset_terr", timeout_err, 4'h0);
    axis_resetn = 1'b1;
    prev_s = {seq_done, timeout_err, rst_n_o};
    mon_en = 1'b1;
  endtask

  task automatic drain(input int last_edge);
    wait_edge(last_edge + 5);
    check("scoreboard_empty", exp_q.size(), 0);
  endtask

  initial begin
    int p;

    // 1: all ready from reset
    do_reset(4'hF);
    push_ev(201, 4'b0001, 4'h0, 1'b0);
    push_ev(218, 4'b0011, 4'h0, 1'b0);
    push_ev(235, 4'b0111, 4'h0, 1'b0);
    push_ev(252, 4'b1111, 4'h0, 1'b1);
    drain(252);

    // 2: channel 2 held until sampled ready at E300
    do_reset(4'b1011);
    push_ev(201, 4'b0001, 4'h0, 1'b0);
    push_ev(218, 4'b0011, 4'h0, 1'b0);
    push_ev(300, 4'b0111, 4'h0, 1'b0);
    push_ev(317, 4'b1111, 4'h0, 1'b1);
    wait_edge(299);
    ch_ready[2] = 1'b1;
    drain(317);

    // 3: channel 1 never ready -> forced release on timeout
    do_reset(4'b1101);
    push_ev(201,  4'b0001, 4'h0,    1'b0);
    push_ev(1217, 4'b0011, 4'b0010, 1'b0);
    push_ev(1234, 4'b0111, 4'b0010, 1'b0);
    push_ev(1251, 4'b1111, 4'b0010, 1'b1);
    drain(1251);

    // 4: software re-sequence from DONE; request edge acts as E0
    p = 1301;
    push_ev(p,       4'b0000, 4'h0, 1'b0);
    push_ev(p + 201, 4'b0001, 4'h0, 1'b0);
    push_ev(p + 218, 4'b0011, 4'h0, 1'b0);
    push_ev(p + 235, 4'b0111, 4'h0, 1'b0);
    push_ev(p + 252, 4'b1111, 4'h0, 1'b1);
    wait_edge(p - 1);
    sw_rst_req = 1'b1;
    ch_ready = 4'hF;
    @(posedge clk); #1;
    sw_rst_req = 1'b0;
    check("swreq_busy", seq_busy, 1'b1);
    check("swreq_stage", seq_stage, 4'd0);
    drain(p + 252);

    // 5: one-edge reset during the gap after channel 1, then full replay
    do_reset(4'hF);
    push_ev(201, 4'b0001, 4'h0, 1'b0);
    push_ev(218, 4'b0011, 4'h0, 1'b0);
    push_ev(0,   4'b0000, 4'h0, 1'b0);
    push_ev(201, 4'b0001, 4'h0, 1'b0);
    push_ev(218, 4'b0011, 4'h0, 1'b0);
    push_ev(235, 4'b0111, 4'h0, 1'b0);
    push_ev(252, 4'b1111, 4'h0, 1'b1);
    wait_edge(225);
    axis_resetn = 1'b0;
    @(posedge clk); #1;
    axis_resetn = 1'b1;
    check("midreset_stage", seq_stage, 4'd0);
    check("midreset_busy", seq_busy, 1'b1);
    drain(252);

    // 6: channel 0 ready only after E210 (later by the synchroniser lag if enabled)
    do_reset(4'b1110);
    push_ev(211 + SYNC_LAG, 4'b0001, 4'h0, 1'b0);
    push_ev(228 + SYNC_LAG, 4'b0011, 4'h0, 1'b0);
    push_ev(245 + SYNC_LAG, 4'b0111, 4'h0, 1'b0);
    push_ev(262 + SYNC_LAG, 4'b1111, 4'h0, 1'b1);
    wait_edge(210);
    ch_ready[0] = 1'b1;
    drain(262 + SYNC_LAG);

    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
